cfg_dump_unit: RTL
==================

// Module: cfg_dump_unit
// PURPOSE
//  Read-only configuration discovery block: exposes the packed per-hart cvw_t configuration
//  over an APB read window and as a framed ready/valid stream ending in a CRC-32 word.
//  Sits in the uncore beside the PLIC/CLINT; the debug module and boot firmware use it.
//  It generalises the static parameter package to NHARTS channels, a WORDW bus and runtime dump.
// PARAMETERS
//  CFGW    $bits(cvw_t)  width of one packed configuration vector (bench overrides)
//  WORDW   32            bus/stream word width; 32 or 64
//  NHARTS  1             number of configuration channels, 1..127
//  AW      16            PADDR width
// PORTS
//  clk        in   1             clock, all logic rising-edge
//  reset_n    in   1             asynchronous active-low reset
//  Cfg        in   NHARTS*CFGW   packed configs; hart h at [h*CFGW +: CFGW], static after reset
//  PSEL       in   1             APB select
//  PENABLE    in   1             APB access phase
//  PWRITE     in   1             APB write (writes are ignored, PSLVERR=1)
//  PADDR      in   AW            APB byte address
//  PRDATA     out  WORDW         APB read data (registered)
//  PREADY     out  1             APB ready
//  PSLVERR    out  1             APB error
//  DumpReq    in   1             start a stream dump (pulse or level)
//  DumpHart   in   7             hart to dump, sampled with DumpReq
//  Busy       out  1             dump in progress
//  StrmValid  out  1             stream word valid
//  StrmReady  in   1             stream consumer ready
//  StrmData   out  WORDW         stream word
//  StrmLast   out  1             final (CRC) word of frame
// BEHAVIOUR
//  Reset: PRDATA=0, PREADY=0, PSLVERR=0, Busy=0, StrmValid=0, StrmData=0, StrmLast=0, FSM=IDLE.
//  NW = ceil(CFGW/WORDW); NWP = 2**$clog2(NW). Word w of hart h = cfg[w*WORDW +: WORDW],
//  MSBs beyond CFGW read zero. Word 0 holds the config LSBs.
//  APB: word index I = PADDR[AW-1:$clog2(WORDW/8)]; h = I/NWP, w = I%NWP.
//   Access phase (PSEL&PENABLE) with PREADY=0 -> next cycle PREADY=1 with PRDATA registered
//   (exactly one wait state); PREADY drops the cycle after. w>=NW -> PRDATA=0, PSLVERR=0;
//   h>=NHARTS or PWRITE=1 -> PRDATA=0, PSLVERR=1. APB is fully independent of the dump FSM.
//  Dump FSM: IDLE -> HDR -> DATA -> CRC -> IDLE.
//   IDLE: DumpReq=1 latches DumpHart, Busy=1, loads header, StrmValid=1 next cycle.
//     DumpReq while Busy=1 is ignored (no queueing).
//   Header = {zero-pad, 16'hC5A7, ERR, hart[6:0], NW[7:0]}; ERR=1 if DumpHart>=NHARTS.
//   A word advances only on StrmValid&StrmReady; StrmData/StrmLast hold stable while stalled.
//   HDR handshake -> DATA (w=0), or CRC if ERR. DATA: NW words, w increments per handshake,
//   last data handshake -> CRC. CRC: StrmLast=1; handshake -> IDLE, StrmValid=0, Busy=0
//   in the following cycle. Back-to-back: a new DumpReq is accepted in the first IDLE cycle.
//  CRC-32: poly 04C11DB7, init FFFFFFFF, non-reflected, MSB-first over every WORDW bit of
//   header and data words, final XOR FFFFFFFF; CRC word = {zero-pad, crc[31:0]}.
//   CRC register updates on each header/data handshake, reinitialised on dump start.
//  reset_n low mid-dump aborts the frame immediately; no partial CRC is emitted.
//  Zero-latency throughput: StrmReady held 1 gives one word per cycle, frame = NW+2 cycles.
// STRUCTURE
//  Package cfgdump_pkg: CFGDUMP_MAGIC=16'hC5A7, CRC32_POLY/INIT/XOROUT, dumpstate_t enum
//   {IDLE,HDR,DATA,CRC}.
//  Sub-module crc32_word (combinational, parameter WORDW): crc_next = f(crc_cur, word).
//  Word select mux shared as a function; APB and stream each use their own instance.
// TESTING
//  Reset: hold reset_n=0 with DumpReq=1 -> all outputs 0, no stream activity until release.
//  CFGW=40,WORDW=32,NHARTS=2, Cfg[39:0]=40'hAB_1234_5678: APB read PADDR=0 -> 0x12345678,
//   PADDR=4 -> 0x000000AB, PREADY exactly one wait state, PSLVERR=0.
//  Same config: PADDR=16 (hart 2) -> PRDATA=0, PSLVERR=1; write PADDR=0 -> PSLVERR=1.
//  DumpReq, DumpHart=1, StrmReady=1 -> 4 words: 0xC5A70102, data0, data1, CRC (matches ref
//   model), StrmLast only on word 4, Busy low the cycle after.
//  StrmReady random 30% -> StrmData stable under stall; DumpReq mid-frame ignored; CRC matches.
//  DumpHart=5 -> header 0xC5A78502 then CRC word (2 words total, StrmLast on second).

Source files
------------

// File: rtl/cfgdump_pkg.sv
// cfgdump_pkg: shared constants and types for the configuration dump unit.
// Holds the frame magic, CRC-32 parameters and the dump FSM state encoding.
package cfgdump_pkg;

    localparam logic [15:0] CFGDUMP_MAGIC = 16'hC5A7;

    localparam logic [31:0] CRC32_POLY   = 32'h04C1_1DB7;
    localparam logic [31:0] CRC32_INIT   = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_XOROUT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA,
        CRC
    } dumpstate_t;

endpackage

// File: rtl/crc32_word.sv
// crc32_word: combinational CRC-32 step over one WORDW-bit word, MSB first.
// Ports: crc_i (current CRC), word_i (word to absorb), crc_o (updated CRC).
module crc32_word
    import cfgdump_pkg::*;
#(
    parameter int WORDW = 32
) (
    input  logic [31:0]      crc_i,
    input  logic [WORDW-1:0] word_i,
    output logic [31:0]      crc_o
);

    logic [31:0] c;

    // Bit-serial non-reflected division, unrolled across the whole word.
    always_comb begin
        c = crc_i;
        for (int i = WORDW - 1; i >= 0; i--) begin
            if (c[31] ^ word_i[i]) begin
                c = {c[30:0], 1'b0} ^ CRC32_POLY;
            end else begin
                c = {c[30:0], 1'b0};
            end
        end
        crc_o = c;
    end

endmodule

// File: rtl/cfg_dump_unit.sv
// cfg_dump_unit: read-only per-hart configuration discovery over APB and a CRC-framed stream.
// Ports: clk/reset_n; Cfg packed configs; APB slave (PSEL..PSLVERR); dump control
// (DumpReq, DumpHart, Busy); stream out (StrmValid, StrmReady, StrmData, StrmLast).
module cfg_dump_unit
    import cfgdump_pkg::*;
#(
    parameter int CFGW   = 64,
    parameter int WORDW  = 32,
    parameter int NHARTS = 1,
    parameter int AW     = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NHARTS*CFGW-1:0] Cfg,
    input  logic                   PSEL,
    input  logic                   PENABLE,
    input  logic                   PWRITE,
    input  logic [AW-1:0]          PADDR,
    output logic [WORDW-1:0]       PRDATA,
    output logic                   PREADY,
    output logic                   PSLVERR,
    input  logic                   DumpReq,
    input  logic [6:0]             DumpHart,
    output logic                   Busy,
    output logic                   StrmValid,
    input  logic                   StrmReady,
    output logic [WORDW-1:0]       StrmData,
    output logic                   StrmLast
);

    localparam int unsigned NW    = (CFGW + WORDW - 1) / WORDW;
    localparam int unsigned NWP   = 1 << $clog2(NW);
    localparam int unsigned NH    = NHARTS;
    localparam int          BSH   = $clog2(WORDW / 8);
    localparam int          PADW  = NW * WORDW;
    localparam int          WIW   = $clog2(NW + 1);
    localparam logic [WIW-1:0] LASTW = WIW'(NW - 1);

    // Word w of hart h, zero-padded above CFGW. Callers guarantee h < NHARTS.
    function automatic logic [WORDW-1:0] cfg_word(
        input logic [6:0]  h,
        input int unsigned w
    );
        logic [PADW-1:0] pad;
        pad            = '0;
        pad[CFGW-1:0]  = Cfg[int'(h)*CFGW +: CFGW];
        return pad[w*WORDW +: WORDW];
    endfunction

    // ---------------- APB read window ----------------
    int unsigned      a_idx;
    int unsigned      a_h;
    int unsigned      a_w;
    logic [WORDW-1:0] a_data;
    logic             a_err;

    always_comb begin
        a_idx  = int'(PADDR) >> BSH;
        a_h    = a_idx / NWP;
        a_w    = a_idx % NWP;
        a_data = '0;
        a_err  = 1'b0;
        if (PWRITE || a_h >= NH) begin
            a_err = 1'b1;
        end else if (a_w < NW) begin
            a_data = cfg_word(7'(a_h), a_w);
        end
    end

    logic [WORDW-1:0] prdata_q;
    logic             pready_q;
    logic             pslverr_q;

    // One wait state: respond the cycle after the access phase is seen.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else if (PSEL && PENABLE && !pready_q) begin
            prdata_q  <= a_data;
            pready_q  <= 1'b1;
            pslverr_q <= a_err;
        end else begin
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end
    end

    assign PRDATA  = prdata_q;
    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;

    // ---------------- Dump stream ----------------
    dumpstate_t     state_q, state_d;
    logic [6:0]     hart_q, hart_d;
    logic           err_q, err_d;
    logic [WIW-1:0] widx_q, widx_d;
    logic [31:0]    crc_q, crc_d;
    logic [31:0]    crc_nx;
    logic [31:0]    hdr32;
    logic           hs;

    assign hdr32 = {CFGDUMP_MAGIC, err_q, hart_q, 8'(NW)};
    assign hs    = StrmValid && StrmReady;

    // Output word is a pure function of held state, so it is stable under stall.
    always_comb begin
        StrmData = '0;
        unique case (state_q)
            IDLE: StrmData = '0;
            HDR:  StrmData = WORDW'(hdr32);
            DATA: StrmData = cfg_word(hart_q, int'(widx_q));
            CRC:  StrmData = WORDW'(crc_q ^ CRC32_XOROUT);
            default: StrmData = '0;
        endcase
    end

    crc32_word #(
        .WORDW (WORDW)
    ) u_crc (
        .crc_i  (crc_q),
        .word_i (StrmData),
        .crc_o  (crc_nx)
    );

    always_comb begin
        state_d = state_q;
        hart_d  = hart_q;
        err_d   = err_q;
        widx_d  = widx_q;
        crc_d   = crc_q;
        unique case (state_q)
            IDLE: begin
                if (DumpReq) begin
                    state_d = HDR;
                    hart_d  = DumpHart;
                    err_d   = 32'(DumpHart) >= NH;
                    widx_d  = '0;
                    crc_d   = CRC32_INIT;
                end
            end
            HDR: begin
                if (hs) begin
                    crc_d   = crc_nx;
                    widx_d  = '0;
                    state_d = err_q ? CRC : DATA;
                end
            end
            DATA: begin
                if (hs) begin
                    crc_d = crc_nx;
                    if (widx_q == LASTW) begin
                        state_d = CRC;
                    end else begin
                        widx_d = widx_q + 1'b1;
                    end
                end
            end
            CRC: begin
                if (hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            hart_q  <= '0;
            err_q   <= 1'b0;
            widx_q  <= '0;
            crc_q   <= CRC32_INIT;
        end else begin
            state_q <= state_d;
            hart_q  <= hart_d;
            err_q   <= err_d;
            widx_q  <= widx_d;
            crc_q   <= crc_d;
        end
    end

    assign Busy      = (state_q != IDLE);
    assign StrmValid = (state_q != IDLE);
    assign StrmLast  = (state_q == CRC);

endmodule
